// File: rtl/svc_rv_fp_mc_seq_pkg.sv
// rtl/svc_rv_fp_mc_seq_pkg.sv - shared FP flag definitions for the multi-cycle sequencer
package svc_rv_fp_mc_seq_pkg;

  // Accrued exception flags, bit order {NV,DZ,OF,UF,NX}
  localparam int FFLAGS_W = 5;
  localparam int FF_NV    = 4;
  localparam int FF_DZ    = 3;
  localparam int FF_OF    = 2;
  localparam int FF_UF    = 1;
  localparam int FF_NX    = 0;

  typedef logic [FFLAGS_W-1:0] fflags_t;

  // A CSR write replaces the accumulator, but flags captured in the same
  // cycle must still stick on top of the written value.
  function automatic fflags_t fflags_next(input logic    csr_we,
                                          input fflags_t csr_wdata,
                                          input fflags_t acc,
                                          input fflags_t captured);
    return (csr_we ? csr_wdata : acc) | captured;
  endfunction

endpackage

// File: rtl/svc_rv_fp_mc_seq.sv
// rtl/svc_rv_fp_mc_seq.sv - issue/stall/writeback sequencer for FDIV.S and FSQRT.S
module svc_rv_fp_mc_seq
  import svc_rv_fp_mc_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic                ex_is_mc,
  input  logic [4:0]          ex_rd,
  input  logic                flush,
  output logic                fpu_op_valid,
  input  logic                fpu_result_valid,
  input  logic [31:0]         fpu_result,
  input  logic [FFLAGS_W-1:0] fpu_fflags,
  output logic                stall,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [4:0]          wb_rd,
  output logic [31:0]         wb_result,
  input  logic                csr_fflags_we,
  input  logic [FFLAGS_W-1:0] csr_fflags_wdata,
  output logic [FFLAGS_W-1:0] fflags_acc,
  output logic                timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    cnt;
  logic          accept;
  logic          capture;
  logic          cnt_clr;
  logic          cnt_inc;
  fflags_t       captured;

  // Flags only reach the accumulator when a live (unflushed) op completes
  assign captured = capture ? fpu_fflags : '0;

  // Next-state decode plus all handshake and stall outputs
  always_comb begin
    state_nxt    = state;
    fpu_op_valid = 1'b0;
    stall        = 1'b0;
    wb_valid     = 1'b0;
    timeout      = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    case (state)
      S_IDLE: begin
        if (ex_valid && ex_is_mc && !flush) begin
          accept    = 1'b1;
          stall     = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        fpu_op_valid = (state == S_ISSUE);
        stall        = 1'b1;
        if (flush) begin
          // A result arriving with the flush is already drained
          state_nxt = fpu_result_valid ? S_IDLE : S_DRAIN;
          cnt_clr   = !fpu_result_valid;
        end else if (fpu_result_valid) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end else if (state == S_ISSUE) begin
          cnt_clr   = 1'b1;
          state_nxt = S_WAIT;
        end else if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_HOLD: begin
        wb_valid = !flush;
        stall    = !wb_ready;
        if (flush || wb_ready) state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        stall = 1'b1;
        if (fpu_result_valid) begin
          state_nxt = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and inline timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 8'd1;
    end
  end

  // Destination, result and sticky flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_rd      <= '0;
      wb_result  <= '0;
      fflags_acc <= '0;
    end else begin
      if (accept)  wb_rd     <= ex_rd;
      if (capture) wb_result <= fpu_result;
      fflags_acc <= fflags_next(csr_fflags_we, csr_fflags_wdata, fflags_acc, captured);
    end
  end

endmodule

// File: tb/tb_svc_rv_fp_mc_seq.sv
// tb/tb_svc_rv_fp_mc_seq.sv - self-checking bench for svc_rv_fp_mc_seq
module tb_svc_rv_fp_mc_seq;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_mc, flush;
  logic [4:0]  ex_rd;
  logic        fpu_op_valid, fpu_result_valid;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_fflags;
  logic        stall, wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        csr_fflags_we;
  logic [4:0]  csr_fflags_wdata;
  logic [4:0]  fflags_acc;
  logic        timeout;

  int checks   = 0;
  int failures = 0;
  int n_opv    = 0;
  int n_to     = 0;
  logic mon_en = 1'b0;

  // Operation-level model: one op in flight at most
  logic        m_busy, m_first, m_squashed, m_have_res;
  logic [4:0]  m_rd, m_acc, m_capt;
  logic [31:0] m_res;
  int          m_waited;
  logic        e_accept, e_stall, e_wbv, e_to, e_opv;

  always #5 clk = ~clk;

  svc_rv_fp_mc_seq #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_mc(ex_is_mc), .ex_rd(ex_rd),
    .flush(flush), .fpu_op_valid(fpu_op_valid), .fpu_result_valid(fpu_result_valid),
    .fpu_result(fpu_result), .fpu_fflags(fpu_fflags), .stall(stall), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_result(wb_result), .csr_fflags_we(csr_fflags_we),
    .csr_fflags_wdata(csr_fflags_wdata), .fflags_acc(fflags_acc), .timeout(timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, then advance the model
  always @(negedge clk) begin
    if (mon_en) begin
      e_accept = !m_busy && ex_valid && ex_is_mc && !flush;
      e_opv    = m_busy && m_first;
      e_stall  = !m_busy ? e_accept : (m_have_res ? !wb_ready : 1'b1);
      e_wbv    = m_busy && m_have_res && !flush;
      e_to     = m_busy && !m_have_res && !m_first && !fpu_result_valid &&
                 (m_squashed || !flush) && (m_waited == TO - 1);
      chk("fpu_op_valid", {31'd0, fpu_op_valid}, {31'd0, e_opv});
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, e_wbv});
      chk("timeout", {31'd0, timeout}, {31'd0, e_to});
      chk("fflags_acc", {27'd0, fflags_acc}, {27'd0, m_acc});
      if (e_wbv) begin
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
        chk("wb_result", wb_result, m_res);
      end
      if (fpu_op_valid) n_opv++;
      if (timeout) n_to++;

      m_capt = 5'd0;
      if (rst) begin
        m_busy = 0; m_first = 0; m_squashed = 0; m_have_res = 0;
        m_acc = 0; m_waited = 0;
      end else begin
        if (!m_busy) begin
          if (e_accept) begin
            m_busy = 1; m_first = 1; m_squashed = 0; m_have_res = 0; m_rd = ex_rd;
          end
        end else if (m_have_res) begin
          if (flush || wb_ready) begin
            m_busy = 0; m_have_res = 0;
          end
        end else if (fpu_result_valid) begin
          if (m_squashed || flush) m_busy = 0;
          else begin
            m_have_res = 1; m_res = fpu_result; m_capt = fpu_fflags;
          end
          m_first = 0;
        end else if (flush && !m_squashed) begin
          m_squashed = 1; m_waited = 0; m_first = 0;
        end else if (e_to) begin
          m_busy = 0;
        end else begin
          if (m_first) m_waited = 0;
          else m_waited++;
          m_first = 0;
        end
        m_acc = (csr_fflags_we ? csr_fflags_wdata : m_acc) | m_capt;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start_op(input logic [4:0] rd);
    ex_valid = 1; ex_is_mc = 1; ex_rd = rd;
    tick();
    ex_valid = 0; ex_is_mc = 0;
  endtask

  task automatic strobe(input logic [31:0] res, input logic [4:0] fl);
    fpu_result_valid = 1; fpu_result = res; fpu_fflags = fl;
    tick();
    fpu_result_valid = 0; fpu_fflags = 0;
  endtask

  initial begin
    m_busy = 0; m_first = 0; m_squashed = 0; m_have_res = 0;
    m_acc = 0; m_rd = 0; m_res = 0; m_waited = 0;
    rst = 1; ex_valid = 0; ex_is_mc = 0; ex_rd = 0; flush = 0;
    fpu_result_valid = 0; fpu_result = 0; fpu_fflags = 0; wb_ready = 0;
    csr_fflags_we = 0; csr_fflags_wdata = 0;
    tick();
    mon_en = 1;
    @(negedge clk);
    chk("reset_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("reset_wb_result", wb_result, 32'd0);
    chk("reset_fflags", {27'd0, fflags_acc}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    tick();
    rst = 0;

    // FDIV rd=7, result three cycles after issue, immediate grant
    wb_ready = 1;
    ex_valid = 1; ex_is_mc = 1; ex_rd = 7;
    @(negedge clk);
    chk("accept_stall", {31'd0, stall}, 32'd1);
    tick();
    ex_valid = 0; ex_is_mc = 0;
    @(negedge clk);
    chk("issue_pulse", {31'd0, fpu_op_valid}, 32'd1);
    idle(2);
    strobe(32'h3F80_0000, 5'h00);
    @(negedge clk);
    chk("t1_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t1_wb_rd", {27'd0, wb_rd}, 32'd7);
    chk("t1_wb_result", wb_result, 32'h3F80_0000);
    chk("t1_stall_handshake", {31'd0, stall}, 32'd0);
    idle(3);

    // Same op, write port withheld for four cycles
    wb_ready = 0;
    start_op(7);
    idle(2);
    strobe(32'h4049_0FDB, 5'h00);
    idle(4);
    wb_ready = 1;
    @(negedge clk);
    chk("t2_grant_stall", {31'd0, stall}, 32'd0);
    chk("t2_held_result", wb_result, 32'h4049_0FDB);
    idle(2);

    // Flush two cycles after issue; late result and flags discarded
    start_op(3);
    idle(2);
    flush = 1;
    tick();
    flush = 0;
    idle(4);
    strobe(32'hDEAD_BEEF, 5'h08);
    @(negedge clk);
    chk("t3_fflags_unchanged", {27'd0, fflags_acc}, 32'd0);
    chk("t3_idle_after_drain", {31'd0, stall}, 32'd0);
    idle(2);

    // Flag accumulation, then CSR write in the capture cycle
    start_op(9);
    strobe(32'h4000_0000, 5'h10);
    tick();
    start_op(10);
    tick();
    strobe(32'h3F00_0000, 5'h01);
    tick();
    @(negedge clk);
    chk("t4_acc_0x11", {27'd0, fflags_acc}, 32'h11);
    start_op(11);
    tick();
    csr_fflags_we = 1; csr_fflags_wdata = 5'h02;
    strobe(32'h3E80_0000, 5'h01);
    csr_fflags_we = 0; csr_fflags_wdata = 0;
    tick();
    @(negedge clk);
    chk("t4_acc_0x03", {27'd0, fflags_acc}, 32'h03);
    csr_fflags_we = 1; csr_fflags_wdata = 5'h04;
    tick();
    csr_fflags_we = 0; csr_fflags_wdata = 0;
    @(negedge clk);
    chk("t4_csr_write", {27'd0, fflags_acc}, 32'h04);
    idle(1);

    // No result: timeout after TO cycles waiting, then accept at once
    start_op(12);
    tick();
    idle(TO - 1);
    @(negedge clk);
    chk("t5_timeout_pulse", {31'd0, timeout}, 32'd1);
    tick();
    start_op(13);
    strobe(32'h4080_0000, 5'h00);
    tick();
    idle(1);

    // Reset while waiting; stray result afterwards is ignored
    start_op(14);
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("t6_stall", {31'd0, stall}, 32'd0);
    chk("t6_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("t6_fflags", {27'd0, fflags_acc}, 32'd0);
    strobe(32'h1234_5678, 5'h1F);
    idle(2);
    @(negedge clk);
    chk("t6_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("t6_stray_result_result", wb_result, 32'd0);
    chk("t6_stray_fflags", {27'd0, fflags_acc}, 32'd0);

    chk("issue_pulse_count", n_opv, 32'd9);
    chk("timeout_pulse_count", n_to, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
